// File: rtl/hazard_interlock_ctrl_pkg.sv
// Shared types for the hazard interlock controller.
//   ctrl_state_t : controller state encodings RUN/STALL/FLUSH (exposed on Ctrl_State)
//   sb_slot_t    : one scoreboard slot {valid, gpr_wr, dst, hilo_wr}
//   REG_ZERO     : architectural $0, which never creates a dependency
package hazard_interlock_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic       valid;
    logic       gpr_wr;
    logic [4:0] dst;
    logic       hilo_wr;
  } sb_slot_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_interlock_ctrl_sb_match.sv
// Combinational compare of one scoreboard slot against the operands read
// by the instruction currently in DEC.
//   slot     : scoreboard slot under test
//   slotEn   : 0 masks this slot entirely (used for the WB slot)
//   rs, rt   : source register numbers of the DEC instruction
//   usesRs   : DEC reads rs
//   usesRt   : DEC reads rt
//   usesHiLo : DEC reads HI or LO
//   hit      : slot produces something DEC still needs
module hazard_interlock_ctrl_sb_match
  import hazard_interlock_ctrl_pkg::*;
(
  input  sb_slot_t   slot,
  input  logic       slotEn,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       usesRs,
  input  logic       usesRt,
  input  logic       usesHiLo,
  output logic       hit
);

  logic live;
  logic rsHit;
  logic rtHit;
  logic hiloHit;

  always_comb begin
    live    = slotEn && slot.valid;
    // $0 reads are excluded here, so a write to $0 can never stall anyone.
    rsHit   = usesRs && (rs != REG_ZERO) && slot.gpr_wr && (slot.dst == rs);
    rtHit   = usesRt && (rt != REG_ZERO) && slot.gpr_wr && (slot.dst == rt);
    hiloHit = usesHiLo && slot.hilo_wr;
    hit     = live && (rsHit || rtHit || hiloHit);
  end

endmodule

// File: rtl/hazard_interlock_ctrl.sv
// Pipeline sequencing controller for a 5-stage MIPS datapath without
// forwarding. A shadow scoreboard (EX, MEM, WB slots) tracks in-flight GPR
// and HI/LO writers; DEC is stalled on read-after-write hazards and IF/DEC
// are flushed when EX redirects the PC.
// Ports:
//   Clk, Rst            : clock (rising edge), asynchronous active-low reset
//   Dec_*               : description of the instruction currently in DEC
//   Ex_Redirect         : EX takes a branch/jump/jr this cycle
//   Cnt_Clr             : synchronous clear of both performance counters
//   PCWrite_En          : PC may load its next value
//   FeDec_Write_En      : FE_DEC register may load
//   FeDec_Flush         : FE_DEC loads a nop
//   DecEx_Bubble        : DEC_EX loads all-zero control
//   Stall_Count         : saturating count of stalled cycles
//   Flush_Count         : saturating count of redirects
//   Ctrl_State          : registered controller state (RUN/STALL/FLUSH)
//
// Control semantics: the pipeline has no valid/ready handshake; the enables
// below act as per-cycle load strobes. A stage register whose write enable is
// low holds its content; a flush or bubble loads all-zero content at the
// same edge. The enables are combinational from this cycle's inputs and the
// scoreboard, so the datapath acts on them at the very next clock edge.
module hazard_interlock_ctrl
  import hazard_interlock_ctrl_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int WB_HAZARD = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Dec_Valid,
  input  logic [4:0]       Dec_Rs,
  input  logic [4:0]       Dec_Rt,
  input  logic             Dec_UsesRs,
  input  logic             Dec_UsesRt,
  input  logic             Dec_UsesHiLo,
  input  logic             Dec_RegWrite,
  input  logic [4:0]       Dec_RegDst,
  input  logic             Dec_HiLoWrite,
  input  logic             Ex_Redirect,
  input  logic             Cnt_Clr,
  output logic             PCWrite_En,
  output logic             FeDec_Write_En,
  output logic             FeDec_Flush,
  output logic             DecEx_Bubble,
  output logic [CNT_W-1:0] Stall_Count,
  output logic [CNT_W-1:0] Flush_Count,
  output logic [1:0]       Ctrl_State
);

  localparam logic WB_EN = (WB_HAZARD != 0);

  sb_slot_t    exSlot;
  sb_slot_t    memSlot;
  sb_slot_t    wbSlot;
  sb_slot_t    decEntry;
  ctrl_state_t state;
  ctrl_state_t nextState;

  logic [2:0] slotHit;
  logic       hazard;
  logic       decAdvance;
  logic       stallEvent;
  logic       flushEvent;

  // Conditional moves arrive with Dec_RegWrite set and are tracked as
  // writers regardless of whether the move will actually happen.
  always_comb begin
    decEntry.valid   = 1'b1;
    decEntry.gpr_wr  = Dec_RegWrite;
    decEntry.dst     = Dec_RegDst;
    decEntry.hilo_wr = Dec_HiLoWrite;
  end

  hazard_interlock_ctrl_sb_match u_match_ex (
    .slot     (exSlot),
    .slotEn   (1'b1),
    .rs       (Dec_Rs),
    .rt       (Dec_Rt),
    .usesRs   (Dec_UsesRs),
    .usesRt   (Dec_UsesRt),
    .usesHiLo (Dec_UsesHiLo),
    .hit      (slotHit[0])
  );

  hazard_interlock_ctrl_sb_match u_match_mem (
    .slot     (memSlot),
    .slotEn   (1'b1),
    .rs       (Dec_Rs),
    .rt       (Dec_Rt),
    .usesRs   (Dec_UsesRs),
    .usesRt   (Dec_UsesRt),
    .usesHiLo (Dec_UsesHiLo),
    .hit      (slotHit[1])
  );

  // The register file writes at the clock edge without write-through, so a
  // WB-resident producer is still unreadable unless WB_HAZARD is cleared.
  hazard_interlock_ctrl_sb_match u_match_wb (
    .slot     (wbSlot),
    .slotEn   (WB_EN),
    .rs       (Dec_Rs),
    .rt       (Dec_Rt),
    .usesRs   (Dec_UsesRs),
    .usesRt   (Dec_UsesRt),
    .usesHiLo (Dec_UsesHiLo),
    .hit      (slotHit[2])
  );

  always_comb begin
    hazard         = Dec_Valid && (|slotHit);
    stallEvent     = hazard && !Ex_Redirect;
    flushEvent     = Ex_Redirect;
    decAdvance     = Dec_Valid && !Ex_Redirect && !hazard;
    nextState      = RUN;
    PCWrite_En     = 1'b1;
    FeDec_Write_En = 1'b1;
    FeDec_Flush    = 1'b0;
    DecEx_Bubble   = 1'b0;
    if (Ex_Redirect) begin
      // The redirect wins over any hazard: the DEC instruction is on the
      // wrong path, so it is squashed rather than held.
      nextState    = FLUSH;
      FeDec_Flush  = 1'b1;
      DecEx_Bubble = 1'b1;
    end else if (hazard) begin
      nextState      = STALL;
      PCWrite_En     = 1'b0;
      FeDec_Write_En = 1'b0;
      DecEx_Bubble   = 1'b1;
    end
    if (!Rst) begin
      PCWrite_En     = 1'b0;
      FeDec_Write_En = 1'b0;
      FeDec_Flush    = 1'b1;
      DecEx_Bubble   = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      exSlot      <= '0;
      memSlot     <= '0;
      wbSlot      <= '0;
      state       <= RUN;
      Stall_Count <= '0;
      Flush_Count <= '0;
    end else begin
      exSlot  <= decAdvance ? decEntry : '0;
      memSlot <= exSlot;
      wbSlot  <= memSlot;
      state   <= nextState;
      if (Cnt_Clr) begin
        Stall_Count <= '0;
      end else if (stallEvent && (Stall_Count != '1)) begin
        Stall_Count <= Stall_Count + CNT_W'(1);
      end
      if (Cnt_Clr) begin
        Flush_Count <= '0;
      end else if (flushEvent && (Flush_Count != '1)) begin
        Flush_Count <= Flush_Count + CNT_W'(1);
      end
    end
  end

  assign Ctrl_State = state;

endmodule

// File: tb/tb_hazard_interlock_ctrl.sv
// Bench for hazard_interlock_ctrl. Two instances share the DEC stimulus:
// u_dut (defaults) and u_dut_nwb (WB slot ignored, 4-bit counters so that
// saturation is reachable). The reference model records, per register and
// for HI/LO, the first cycle at which a reader may proceed.
module tb_hazard_interlock_ctrl;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Dec_Valid = 1'b0;
  logic [4:0]  Dec_Rs = '0;
  logic [4:0]  Dec_Rt = '0;
  logic        Dec_UsesRs = 1'b0;
  logic        Dec_UsesRt = 1'b0;
  logic        Dec_UsesHiLo = 1'b0;
  logic        Dec_RegWrite = 1'b0;
  logic [4:0]  Dec_RegDst = '0;
  logic        Dec_HiLoWrite = 1'b0;
  logic        Ex_Redirect = 1'b0;
  logic        Cnt_Clr = 1'b0;

  logic        pcw0, few0, fl0, bub0;
  logic [15:0] stc0, flc0;
  logic [1:0]  st0;
  logic        pcw1, few1, fl1, bub1;
  logic [3:0]  stc1, flc1;
  logic [1:0]  st1;

  logic [3:0] ctl0, ctl1;
  assign ctl0 = {pcw0, few0, fl0, bub0};
  assign ctl1 = {pcw1, few1, fl1, bub1};

  int n_checks = 0;
  int n_pass   = 0;

  // clock / reset
  always #5 Clk = ~Clk;

  hazard_interlock_ctrl u_dut (
    .Clk(Clk), .Rst(Rst), .Dec_Valid(Dec_Valid), .Dec_Rs(Dec_Rs), .Dec_Rt(Dec_Rt),
    .Dec_UsesRs(Dec_UsesRs), .Dec_UsesRt(Dec_UsesRt), .Dec_UsesHiLo(Dec_UsesHiLo),
    .Dec_RegWrite(Dec_RegWrite), .Dec_RegDst(Dec_RegDst), .Dec_HiLoWrite(Dec_HiLoWrite),
    .Ex_Redirect(Ex_Redirect), .Cnt_Clr(Cnt_Clr), .PCWrite_En(pcw0),
    .FeDec_Write_En(few0), .FeDec_Flush(fl0), .DecEx_Bubble(bub0),
    .Stall_Count(stc0), .Flush_Count(flc0), .Ctrl_State(st0)
  );

  hazard_interlock_ctrl #(.CNT_W(4), .WB_HAZARD(0)) u_dut_nwb (
    .Clk(Clk), .Rst(Rst), .Dec_Valid(Dec_Valid), .Dec_Rs(Dec_Rs), .Dec_Rt(Dec_Rt),
    .Dec_UsesRs(Dec_UsesRs), .Dec_UsesRt(Dec_UsesRt), .Dec_UsesHiLo(Dec_UsesHiLo),
    .Dec_RegWrite(Dec_RegWrite), .Dec_RegDst(Dec_RegDst), .Dec_HiLoWrite(Dec_HiLoWrite),
    .Ex_Redirect(Ex_Redirect), .Cnt_Clr(Cnt_Clr), .PCWrite_En(pcw1),
    .FeDec_Write_En(few1), .FeDec_Flush(fl1), .DecEx_Bubble(bub1),
    .Stall_Count(stc1), .Flush_Count(flc1), .Ctrl_State(st1)
  );

  // ---------------- reference model ----------------
  int cyc = 0;
  int gprReady [2][32];
  int hiloReady[2];
  int mStall[2];
  int mFlush[2];
  int mState[2];
  int cntMax[2] = '{65535, 15};
  int lat[2]    = '{4, 3};       // cycles after issue before a reader may go
  logic [3:0] expCtl[2];

  logic [51:0] exp_q[$];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int r = 0; r < 32; r++) gprReady[m][r] = 0;
      hiloReady[m] = 0;
      mStall[m] = 0;
      mFlush[m] = 0;
      mState[m] = 0;
    end
  endtask

  function automatic bit model_hazard(int m);
    bit h;
    h = 1'b0;
    if (Dec_Valid) begin
      if (Dec_UsesRs && Dec_Rs != 5'd0 && cyc < gprReady[m][Dec_Rs]) h = 1'b1;
      if (Dec_UsesRt && Dec_Rt != 5'd0 && cyc < gprReady[m][Dec_Rt]) h = 1'b1;
      if (Dec_UsesHiLo && cyc < hiloReady[m]) h = 1'b1;
    end
    return h;
  endfunction

  // ---------------- driver tasks ----------------
  // Called just after a falling edge; applies DEC inputs and computes the
  // expected combinational controls for this cycle.
  task automatic drive_dec(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                           input bit ur, input bit urt, input bit uhl, input bit rw,
                           input logic [4:0] dst, input bit hw, input bit redir,
                           input bit clr);
    Dec_Valid = v; Dec_Rs = rs; Dec_Rt = rt; Dec_UsesRs = ur; Dec_UsesRt = urt;
    Dec_UsesHiLo = uhl; Dec_RegWrite = rw; Dec_RegDst = dst; Dec_HiLoWrite = hw;
    Ex_Redirect = redir; Cnt_Clr = clr;
    #1;
    for (int m = 0; m < 2; m++) begin
      if (Ex_Redirect) expCtl[m] = 4'b1111;
      else if (model_hazard(m)) expCtl[m] = 4'b0001;
      else expCtl[m] = 4'b1100;
    end
  endtask

  // Commits the current cycle into the model and moves to the next falling edge.
  task automatic advance();
    for (int m = 0; m < 2; m++) begin
      bit h;
      h = model_hazard(m);
      if (Cnt_Clr) mStall[m] = 0;
      else if (h && !Ex_Redirect && mStall[m] < cntMax[m]) mStall[m]++;
      if (Cnt_Clr) mFlush[m] = 0;
      else if (Ex_Redirect && mFlush[m] < cntMax[m]) mFlush[m]++;
      mState[m] = Ex_Redirect ? 2 : (h ? 1 : 0);
      if (!Ex_Redirect && !h && Dec_Valid) begin
        if (Dec_RegWrite) gprReady[m][Dec_RegDst] = cyc + lat[m];
        if (Dec_HiLoWrite) hiloReady[m] = cyc + lat[m];
      end
    end
    cyc++;
    @(negedge Clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Rst = 1'b0;
    #1;
    n_checks++; if (ctl0 !== 4'b0011) $display("FAIL reset_ctl0: got %b expected 0011", ctl0); else n_pass++;
    n_checks++; if (ctl1 !== 4'b0011) $display("FAIL reset_ctl1: got %b expected 0011", ctl1); else n_pass++;
    n_checks++; if ({stc0, flc0, st0} !== 34'd0) $display("FAIL reset_regs: got %h expected 0", {stc0, flc0, st0}); else n_pass++;
    model_reset();
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
  endtask

  task automatic test_back_to_back();
    int stalls = 0;
    int start_stall = mStall[0];
    drive_dec(1, 5'd1, 5'd2, 1, 1, 0, 1, 5'd3, 0, 0, 0);   // add $3,$1,$2
    n_checks++; if (ctl0 !== 4'b1100) $display("FAIL b2b_first: got %b expected 1100", ctl0); else n_pass++;
    advance();
    for (int i = 0; i < 10; i++) begin
      drive_dec(1, 5'd3, 5'd5, 1, 1, 0, 1, 5'd4, 0, 0, 0); // add $4,$3,$5
      n_checks++; if (ctl0 !== expCtl[0]) $display("FAIL b2b_ctl0: got %b expected %b", ctl0, expCtl[0]); else n_pass++;
      n_checks++; if (ctl1 !== expCtl[1]) $display("FAIL b2b_ctl1: got %b expected %b", ctl1, expCtl[1]); else n_pass++;
      if (pcw0 === 1'b1) begin advance(); break; end
      stalls++;
      advance();
    end
    n_checks++; if (stalls != 3) $display("FAIL b2b_stall_cycles: got %0d expected 3", stalls); else n_pass++;
    n_checks++; if (stc0 !== 16'(start_stall + 3)) $display("FAIL b2b_stall_count: got %0d expected %0d", stc0, start_stall + 3); else n_pass++;
  endtask

  task automatic test_load_use();
    int stalls = 0;
    int ones = 0;
    drive_dec(1, 5'd9, 5'd0, 1, 0, 0, 1, 5'd8, 0, 0, 0);   // lw $8,0($9)
    advance();
    for (int k = 0; k < 2; k++) begin                      // independent ops
      drive_dec(1, 5'd1, 5'd2, 1, 1, 0, 0, 5'd0, 0, 0, 0);
      n_checks++; if (ctl0 !== 4'b1100) $display("FAIL lu_indep: got %b expected 1100", ctl0); else n_pass++;
      advance();
    end
    for (int i = 0; i < 10; i++) begin
      drive_dec(1, 5'd9, 5'd8, 1, 1, 0, 0, 5'd0, 0, 0, 0); // sw $8,0($9)
      n_checks++; if (ctl0 !== expCtl[0]) $display("FAIL lu_ctl0: got %b expected %b", ctl0, expCtl[0]); else n_pass++;
      if (st0 === 2'd1) ones++;
      if (pcw0 === 1'b1) begin advance(); break; end
      stalls++;
      advance();
    end
    drive_dec(0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0);
    n_checks++; if (st0 !== 2'd0) $display("FAIL lu_state_after: got %0d expected 0", st0); else n_pass++;
    advance();
    n_checks++; if (stalls != 1) $display("FAIL lu_stall_cycles: got %0d expected 1", stalls); else n_pass++;
    n_checks++; if (ones != 1) $display("FAIL lu_state_stall: got %0d cycles expected 1", ones); else n_pass++;
  endtask

  task automatic test_zero_reg();
    drive_dec(1, 5'd1, 5'd0, 1, 0, 0, 1, 5'd0, 0, 0, 0);   // addi $0,$1,imm
    advance();
    for (int k = 0; k < 3; k++) begin
      drive_dec(1, 5'd0, 5'd0, 1, 1, 0, 1, 5'd7, 0, 0, 0); // reads $0
      n_checks++; if (pcw0 !== 1'b1 || ctl0 !== expCtl[0]) $display("FAIL zero_no_stall: got %b expected %b", ctl0, expCtl[0]); else n_pass++;
      advance();
    end
  endtask

  task automatic test_hilo();
    int stalls = 0;
    drive_dec(0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 1);   // counter clear
    advance();
    n_checks++; if (stc0 !== 16'd0 || stc1 !== 4'd0) $display("FAIL hilo_clr: got %0d/%0d expected 0/0", stc0, stc1); else n_pass++;
    drive_dec(1, 5'd1, 5'd2, 1, 1, 0, 0, 5'd0, 1, 0, 0);   // mult $1,$2
    advance();
    for (int i = 0; i < 10; i++) begin
      drive_dec(1, 5'd0, 5'd0, 0, 0, 1, 1, 5'd6, 0, 0, 0); // mfhi $6
      n_checks++; if (ctl1 !== expCtl[1]) $display("FAIL hilo_ctl1: got %b expected %b", ctl1, expCtl[1]); else n_pass++;
      if (pcw0 === 1'b1) begin advance(); break; end
      stalls++;
      advance();
    end
    n_checks++; if (stalls != 3) $display("FAIL hilo_stall_cycles: got %0d expected 3", stalls); else n_pass++;
    n_checks++; if (stc0 !== 16'd3) $display("FAIL hilo_count_wb: got %0d expected 3", stc0); else n_pass++;
    n_checks++; if (stc1 !== 4'd2) $display("FAIL hilo_count_nowb: got %0d expected 2", stc1); else n_pass++;
  endtask

  task automatic test_redirect();
    int stall_before;
    int flush_before;
    drive_dec(1, 5'd1, 5'd2, 1, 1, 0, 1, 5'd3, 0, 0, 0);
    advance();
    stall_before = mStall[0];
    flush_before = mFlush[0];
    drive_dec(1, 5'd3, 5'd3, 1, 1, 0, 1, 5'd4, 0, 1, 0);   // hazard + redirect
    n_checks++; if (ctl0 !== 4'b1111) $display("FAIL redir_ctl: got %b expected 1111", ctl0); else n_pass++;
    advance();
    drive_dec(0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0);
    n_checks++; if (st0 !== 2'd2) $display("FAIL redir_state: got %0d expected 2", st0); else n_pass++;
    n_checks++; if (flc0 !== 16'(flush_before + 1)) $display("FAIL redir_flush_count: got %0d expected %0d", flc0, flush_before + 1); else n_pass++;
    n_checks++; if (stc0 !== 16'(stall_before)) $display("FAIL redir_stall_count: got %0d expected %0d", stc0, stall_before); else n_pass++;
    advance();
  endtask

  task automatic test_random();
    logic [51:0] obs;
    logic [51:0] exp_word;
    for (int i = 0; i < 400; i++) begin
      drive_dec($urandom_range(0, 9) < 8, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0, 1'($urandom),
                5'($urandom_range(0, 7)), $urandom_range(0, 3) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 31) == 0);
      exp_q.push_back({2'(mState[0]), expCtl[0], 16'(mStall[0]), 16'(mFlush[0]),
                       2'(mState[1]), expCtl[1], 4'(mStall[1]), 4'(mFlush[1])});
      obs = {st0, ctl0, stc0, flc0, st1, ctl1, stc1, flc1};
      exp_word = exp_q.pop_front();
      n_checks++; if (obs !== exp_word) $display("FAIL rand_cycle%0d: got %h expected %h", i, obs, exp_word); else n_pass++;
      advance();
    end
  endtask

  task automatic test_saturation();
    for (int g = 0; g < 10; g++) begin
      drive_dec(1, 5'd1, 5'd2, 1, 1, 0, 1, 5'd3, 0, 0, 0);
      advance();
      for (int i = 0; i < 8; i++) begin
        drive_dec(1, 5'd3, 5'd5, 1, 1, 0, 1, 5'd4, 0, 0, 0);
        if (pcw0 === 1'b1) begin advance(); break; end
        advance();
      end
    end
    n_checks++; if (stc1 !== 4'hF || mStall[1] != 15) $display("FAIL sat_stall: got %0d expected 15", stc1); else n_pass++;
    n_checks++; if (stc0 !== 16'(mStall[0])) $display("FAIL sat_stall_wide: got %0d expected %0d", stc0, mStall[0]); else n_pass++;
    // clear coinciding with a stall event: clear wins
    drive_dec(1, 5'd1, 5'd2, 1, 1, 0, 1, 5'd3, 0, 0, 0);
    advance();
    drive_dec(1, 5'd3, 5'd5, 1, 1, 0, 1, 5'd4, 0, 0, 1);
    n_checks++; if (ctl0 !== 4'b0001) $display("FAIL clr_stall_ctl: got %b expected 0001", ctl0); else n_pass++;
    advance();
    n_checks++; if (stc0 !== 16'd0 || stc1 !== 4'd0) $display("FAIL clr_wins: got %0d/%0d expected 0/0", stc0, stc1); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      drive_dec(1, 5'd3, 5'd5, 1, 1, 0, 1, 5'd4, 0, 0, 0);
      if (pcw0 === 1'b1) begin advance(); break; end
      advance();
    end
    for (int i = 0; i < 20; i++) begin
      drive_dec(0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 0);
      advance();
    end
    n_checks++; if (flc1 !== 4'hF) $display("FAIL sat_flush: got %0d expected 15", flc1); else n_pass++;
    n_checks++; if (flc0 !== 16'(mFlush[0])) $display("FAIL sat_flush_wide: got %0d expected %0d", flc0, mFlush[0]); else n_pass++;
  endtask

  task automatic test_reset_mid_stall();
    drive_dec(1, 5'd1, 5'd2, 1, 1, 0, 1, 5'd3, 0, 0, 0);
    advance();
    drive_dec(1, 5'd3, 5'd5, 1, 1, 0, 1, 5'd4, 0, 0, 0);
    n_checks++; if (ctl0 !== 4'b0001) $display("FAIL rst_pre_stall: got %b expected 0001", ctl0); else n_pass++;
    advance();
    Rst = 1'b0;
    #1;
    n_checks++; if (ctl0 !== 4'b0011 || ctl1 !== 4'b0011) $display("FAIL rst_async_ctl: got %b/%b expected 0011", ctl0, ctl1); else n_pass++;
    n_checks++; if ({stc0, flc0, st0, stc1, flc1, st1} !== 44'd0) $display("FAIL rst_async_regs: got %h expected 0", {stc0, flc0, st0, stc1, flc1, st1}); else n_pass++;
    model_reset();
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    drive_dec(1, 5'd3, 5'd5, 1, 1, 0, 1, 5'd4, 0, 0, 0);
    n_checks++; if (ctl0 !== 4'b1100 || ctl1 !== 4'b1100) $display("FAIL rst_release: got %b/%b expected 1100", ctl0, ctl1); else n_pass++;
    n_checks++; if (st0 !== 2'd0) $display("FAIL rst_release_state: got %0d expected 0", st0); else n_pass++;
    advance();
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_zero_reg();
    test_hilo();
    test_redirect();
    test_random();
    test_saturation();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
